mux4_arbiter: RTL and testbench
===============================

# mux4_arbiter

Round-robin arbiter that shares the 4:1 select datapath among four requesters. It grants one requester at a time, drives the mux select from the registered grant, and forces rotation when a grant has been held too long. It sits in front of the 4:1 mux and is the only block allowed to drive its select lines.

## Interface

- `MAX_HOLD`, default 8: maximum consecutive cycles one owner keeps the grant. Legal range 1..2^HOLD_W.
- `HOLD_W`, default 4: width of the hold counter.

- `clk`, input, 1: the single clock, rising-edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req`, input, 4: request per requester; bit i belongs to requester i.
- `din`, input, 4: data bit per requester, routed through the shared mux.
- `gnt`, output, 4: one-hot grant, registered; 4'b0000 when no owner.
- `sel`, output, 2: mux select, registered; equals the index of the set `gnt` bit.
- `busy`, output, 1: registered; 1 while any grant is held.
- `dout`, output, 1: combinational; `din[sel]` when `busy`=1, else 0.

## Operation

- Reset values:
  - `gnt`=0, `sel`=0, `busy`=0.
  - Internal state: state=IDLE, `ptr`=0, `hold_cnt`=0.
  - `dout`=0 follows from `busy`=0.
- Pick function `pick(req, ptr)`: scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4). Return the first index with `req` set, else none.
- State IDLE:
  - If any `req` bit is set, go to GRANT with owner=pick(req, ptr) and `hold_cnt`=0.
  - Otherwise stay in IDLE.
- State GRANT, evaluated every edge:
  - Release: `req[owner]`=0.
  - Timeout: `hold_cnt`==MAX_HOLD-1.
  - Release or timeout: next owner=pick(req, owner+1). Then:
    - If a next owner exists, stay in GRANT and reset `hold_cnt` to 0.
    - If none, go to IDLE.
    - In both cases set `ptr`=owner+1 mod 4.
  - Neither release nor timeout: keep the owner and increment `hold_cnt`.
- Timeout with no other requester: pick returns the same owner, so the grant continues without a gap and `hold_cnt` restarts at 0.
- Handover is back-to-back. A new owner's `gnt` is asserted on the same edge the old owner's `gnt` deasserts. No idle cycle is inserted.
- Simultaneous events:
  - Release and timeout on the same edge are treated as a release.
  - Requests arriving on the handover edge take part in that pick.
- Requesters may raise `req` at any time. A requester dropping `req` while not granted is simply skipped.
- `gnt` is always one-hot or zero; `sel` never changes while `busy`=0.

## Timing

- Latency from `req` to `gnt`: one cycle. A request sampled at edge N produces `gnt` valid after edge N.
- Release latency: `req[owner]` low at edge N means `gnt[owner]` is low after edge N.
- An owner holds the grant for at most MAX_HOLD consecutive cycles before rotation is evaluated.
- `dout` has zero cycles from `din`: purely combinational through the mux, qualified by `busy`.
- Reset asserted mid-grant clears all registers immediately, without waiting for `clk`. The first edge after deassertion behaves as IDLE with `ptr`=0.

## Structure

- Shared include file: state encodings (IDLE=1'b0, GRANT=1'b1) and the default MAX_HOLD/HOLD_W constants.
- Natural sub-module: `rr_pick4`, a combinational rotating priority picker with inputs req[3:0] and ptr[1:0], and outputs idx[1:0] and found.
- The 4:1 mux for `dout` is the existing shared mux, instantiated with `sel`.

## Test plan

- Reset, then `req`=4'b0001 with `din`=4'b0001 → after one edge: `gnt`=0001, `sel`=0, `busy`=1, `dout`=1.
- `req`=4'b1111 held, MAX_HOLD=4 → grants go 0,1,2,3,0, each exactly 4 cycles, with no zero-`gnt` cycle between owners.
- Owner 2 granted with `req`=4'b1111, then `req`=4'b1011 → next edge `gnt`=1000; after requester 3 releases (`req`=0011), `gnt`=0001.
- Only `req[1]` held for 12 cycles, MAX_HOLD=4 → `gnt`=0010 continuously, with `hold_cnt` restarting every 4 cycles.
- Owner 3 releases with `req`=0 → IDLE next edge and `gnt`=0. Then `req`=4'b1111 → `gnt`=0001, because `ptr` wrapped to 0.
- `rst_n` pulsed low mid-grant between edges → `gnt`=0, `busy`=0, `sel`=0 immediately. After release, `req`=4'b0110 → `gnt`=0010.

Source files
------------

// File: rtl/mux4_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux4_arbiter_pkg
// Brief    : Shared state encoding, default sizing and helpers for mux4_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mux4_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int C_MAX_HOLD_DEFAULT = 8;
  localparam int C_HOLD_W_DEFAULT   = 4;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Brief    : Combinational rotating-priority picker; first set req from ptr up.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       found
);

  // Scan farthest-first so the candidate closest to ptr overwrites the rest.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        idx   = ptr + 2'(k);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_arbiter
// Brief    : Round-robin owner of the shared 4:1 select path with hold timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = C_MAX_HOLD_DEFAULT,
  parameter int HOLD_W   = C_HOLD_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       dout
);

  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_sel;
  logic [1:0]        w_sel_nxt;
  logic [1:0]        r_ptr;
  logic [1:0]        w_ptr_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [3:0]        r_gnt;
  logic [3:0]        w_gnt_nxt;
  logic [1:0]        w_scan_base;
  logic [1:0]        w_pick_idx;
  logic              w_pick_found;
  logic              w_release;
  logic              w_timeout;
  logic              w_mux;

  // While granted, the search starts just past the current owner.
  assign w_scan_base = (r_state == ST_GRANT) ? r_sel + 2'd1 : r_ptr;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (w_scan_base),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  assign w_release = ~req[r_sel];
  assign w_timeout = (r_hold_cnt == C_HOLD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_pick_idx;
          w_hold_nxt  = '0;
        end
      end
      ST_GRANT: begin
        if (w_release || w_timeout) begin
          w_ptr_nxt  = r_sel + 2'd1;
          w_hold_nxt = '0;
          if (w_pick_found) begin
            w_sel_nxt = w_pick_idx;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_gnt_nxt = (w_state_nxt == ST_GRANT) ? onehot4(w_sel_nxt) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= 2'd0;
      r_ptr      <= 2'd0;
      r_hold_cnt <= '0;
      r_gnt      <= 4'b0000;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
    end
  end

  // Shared 4:1 data mux, gated so an idle select path reads as zero.
  assign w_mux = din[r_sel];
  assign dout  = (r_state == ST_GRANT) & w_mux;

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = (r_state == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_arbiter
// Brief    : Scoreboard bench for mux4_arbiter against a behavioural owner model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int HOLD_W   = 4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       dout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] din = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       dout;

  int   vectors    = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  // Reference model: current owner (-1 = none), rotation pointer, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_sel   = 0;

  mux4_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_sel   = 0;
  endtask

  // Apply inputs for the coming edge and queue the outputs expected after it.
  task automatic step(input logic [3:0] r, input logic [3:0] d);
    int   n;
    exp_t e;
    @(negedge clk);
    req = r;
    din = d;
    if (m_owner < 0) begin
      n = pick(r, m_ptr);
      if (n >= 0) begin
        m_owner = n;
        m_held  = 1;
      end
    end else if (!r[m_owner] || m_held == MAX_HOLD) begin
      n       = pick(r, m_owner + 1);
      m_ptr   = (m_owner + 1) % 4;
      m_owner = n;
      m_held  = (n >= 0) ? 1 : 0;
    end else begin
      m_held++;
    end
    if (m_owner >= 0) m_sel = m_owner;
    e.gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.sel  = 2'(m_sel);
    e.busy = (m_owner >= 0);
    e.dout = (m_owner >= 0) ? d[m_owner] : 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: reset values checked asynchronously, otherwise pop after each edge.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      vectors++;
      if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || dout !== 1'b0) begin
        miscompares++;
        $display("FAIL reset: got gnt=%b sel=%0d busy=%b dout=%b, want gnt=0000 sel=0 busy=0 dout=0",
                 gnt, sel, busy, dout);
      end
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e.gnt || sel !== e.sel || busy !== e.busy || dout !== e.dout) begin
        miscompares++;
        $display("FAIL cycle@%0t: got gnt=%b sel=%0d busy=%b dout=%b, want gnt=%b sel=%0d busy=%b dout=%b",
                 $time, gnt, sel, busy, dout, e.gnt, e.sel, e.busy, e.dout);
      end
    end
  end

  initial begin
    logic [3:0] r;
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    model_reset();

    // Single requester with data passthrough, then release to idle.
    step(4'b0001, 4'b0001);
    step(4'b0001, 4'b1110);
    step(4'b0000, 4'b1111);

    // All requesting: full rotation with timeouts and no gaps.
    pulse_reset();
    for (int i = 0; i < 20; i++) step(4'b1111, 4'(i));

    // Owner 2 releases to 3, then 3 releases and pick wraps to 0.
    pulse_reset();
    step(4'b0100, 4'b0100);
    step(4'b1111, 4'b0100);
    step(4'b1011, 4'b1000);
    step(4'b0011, 4'b0001);

    // Lone requester keeps the grant across timeouts.
    pulse_reset();
    for (int i = 0; i < 12; i++) step(4'b0010, 4'b0010);

    // Owner 3 drops to idle; pointer wrapped to 0.
    pulse_reset();
    step(4'b1000, 4'b1000);
    step(4'b0000, 4'b0000);
    step(4'b1111, 4'b0001);
    step(4'b1111, 4'b0001);

    // Mid-grant asynchronous reset, then restart from ptr 0.
    pulse_reset();
    step(4'b0110, 4'b0110);

    // Randomised traffic with sticky request patterns.
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, 4'($urandom_range(0, 15)));
      if (i == 200) pulse_reset();
    end

    @(posedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
